// File: rtl/beta_exe_mem_unit.sv
// beta_exe_mem_unit: parametrised execute-stage load/store unit.
// Define BETA_LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses.
module beta_exe_mem_unit #(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 64
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      lsu_en_i,
  input  logic                      lsu_op_i,
  input  logic [1:0]                lsu_size_i,
  input  logic                      lsu_unsigned_i,
  input  logic [AddressWidth-1:0]   lsu_addr_i,
  input  logic [DataWidth-1:0]      lsu_wdata_i,
  output logic                      lsu_busy_o,
  output logic                      lsu_done_o,
  output logic [DataWidth-1:0]      lsu_result_o,
  output logic                      lsu_err_o,
  output logic [1:0]                lsu_err_cause_o,
  input  logic                      rdata_ready_i,
  input  logic                      rdata_valid_i,
  input  logic [DataWidth-1:0]      rdata_data_i,
  output logic [AddressWidth-1:0]   rdata_addr_o,
  output logic [DataWidth/8-1:0]    rdata_strb_o,
  output logic                      rdata_req_o,
  input  logic                      wdata_ready_i,
  input  logic                      wdata_valid_i,
  output logic [DataWidth-1:0]      wdata_data_o,
  output logic [AddressWidth-1:0]   wdata_addr_o,
  output logic [DataWidth/8-1:0]    wdata_strb_o,
  output logic                      wdata_req_o
);

  localparam int DW = DataWidth;
  localparam int AW = AddressWidth;
  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TimeoutCycles + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic          op_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          split_q;
  logic          beat_q;
  logic [DW-1:0] first_q;
  logic [DW-1:0] result_q;
  logic          err_q;
  logic [1:0]    cause_q;
  logic [CW-1:0] cnt_q;

  logic [OW-1:0] in_off;
  logic [2:0]    in_align;
  logic          in_ill;
  logic          in_mis;
  logic          in_cross;

  always_comb begin
    in_off = lsu_addr_i[OW-1:0];
    unique case (lsu_size_i)
      2'b00:   in_align = 3'd0;
      2'b01:   in_align = 3'd1;
      2'b10:   in_align = 3'd3;
      default: in_align = 3'd7;
    endcase
    in_ill = (lsu_size_i == 2'b11) && (DW != 64);
`ifdef BETA_LSU_MISALIGNED_SPLIT_EN
    in_mis   = 1'b0;
    in_cross = (int'(in_off) + int'(in_align) + 1) > NB;
`else
    in_mis   = (3'(in_off) & in_align) != 3'd0;
    in_cross = 1'b0;
`endif
  end

  logic          rdy, vld, more, tmo, beat_ok;
  logic [OW-1:0] off_q;

  assign off_q = addr_q[OW-1:0];
  assign rdy   = op_q ? wdata_ready_i : rdata_ready_i;
  assign vld   = op_q ? wdata_valid_i : rdata_valid_i;
  assign more  = split_q && !beat_q;
  assign tmo   = (TimeoutCycles != 0) &&
                 (CW'(cnt_q + 1'b1) == CW'(TimeoutCycles));
  assign beat_ok = ((state_q == S_REQ) && rdy && vld) ||
                   ((state_q == S_WAIT) && vld);

  logic [NB-1:0]   size_strb;
  logic [2*NB-1:0] strb_wide;
  logic [2*DW-1:0] wd_wide;
  logic [2*DW-1:0] rd_wide;
  logic [DW-1:0]   rd_lo, rd_hi;
  logic [DW-1:0]   ld_mask, ld_raw, ld_val;
  logic            ld_sign;

  always_comb begin
    unique case (size_q)
      2'b00:   size_strb = NB'(1);
      2'b01:   size_strb = NB'(3);
      2'b10:   size_strb = NB'(15);
      default: size_strb = '1;
    endcase
    strb_wide = {{NB{1'b0}}, size_strb} << off_q;
    wd_wide   = {{DW{1'b0}}, wdata_q} << {off_q, 3'b000};
  end

  // Split loads: first beat supplies the low bytes, current beat the high.
  always_comb begin
    rd_lo   = split_q ? first_q : rdata_data_i;
    rd_hi   = split_q ? rdata_data_i : '0;
    rd_wide = {rd_hi, rd_lo} >> {off_q, 3'b000};
    ld_raw  = rd_wide[DW-1:0];
    unique case (size_q)
      2'b00: begin
        ld_mask = DW'(8'hFF);
        ld_sign = ld_raw[7];
      end
      2'b01: begin
        ld_mask = DW'(16'hFFFF);
        ld_sign = ld_raw[15];
      end
      2'b10: begin
        ld_mask = DW'(32'hFFFF_FFFF);
        ld_sign = ld_raw[31];
      end
      default: begin
        ld_mask = '1;
        ld_sign = ld_raw[DW-1];
      end
    endcase
    ld_val = (ld_raw & ld_mask) |
             ((ld_sign && !uns_q) ? ~ld_mask : '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (lsu_en_i)
          state_d = (in_ill || in_mis) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (rdy) begin
          if (!vld)     state_d = S_WAIT;
          else if (more) state_d = S_REQ;
          else          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (vld)      state_d = more ? S_REQ : S_DONE;
        else if (tmo) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      op_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      split_q  <= 1'b0;
      beat_q   <= 1'b0;
      first_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cause_q  <= 2'b00;
      cnt_q    <= '0;
    end else begin
      if ((state_q == S_IDLE) && lsu_en_i) begin
        op_q     <= lsu_op_i;
        size_q   <= lsu_size_i;
        uns_q    <= lsu_unsigned_i;
        addr_q   <= lsu_addr_i;
        wdata_q  <= lsu_wdata_i;
        split_q  <= in_cross;
        beat_q   <= 1'b0;
        result_q <= '0;
        err_q    <= in_ill || in_mis;
        cause_q  <= in_ill ? 2'b11 : (in_mis ? 2'b01 : 2'b00);
      end
      if (beat_ok) begin
        if (more) begin
          first_q <= rdata_data_i;
          beat_q  <= 1'b1;
        end else if (!op_q) begin
          result_q <= ld_val;
        end
      end
      if ((state_q == S_WAIT) && !vld) begin
        cnt_q <= cnt_q + 1'b1;
        if (tmo) begin
          err_q   <= 1'b1;
          cause_q <= 2'b10;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  logic [AW-1:0] beat_addr;
  logic [NB-1:0] beat_strb;
  logic [DW-1:0] beat_wd;
  logic          in_req, done;

  always_comb begin
    beat_addr = {addr_q[AW-1:OW], {OW{1'b0}}} +
                (beat_q ? AW'(NB) : '0);
    beat_strb = beat_q ? strb_wide[2*NB-1:NB] : strb_wide[NB-1:0];
    beat_wd   = beat_q ? wd_wide[2*DW-1:DW] : wd_wide[DW-1:0];
    in_req    = (state_q == S_REQ);
    done      = (state_q == S_DONE);

    lsu_busy_o      = in_req || (state_q == S_WAIT);
    lsu_done_o      = done;
    lsu_result_o    = done ? result_q : '0;
    lsu_err_o       = done && err_q;
    lsu_err_cause_o = done ? cause_q : 2'b00;

    rdata_req_o  = in_req && !op_q;
    rdata_addr_o = rdata_req_o ? beat_addr : '0;
    rdata_strb_o = rdata_req_o ? beat_strb : '0;
    wdata_req_o  = in_req && op_q;
    wdata_addr_o = wdata_req_o ? beat_addr : '0;
    wdata_strb_o = wdata_req_o ? beat_strb : '0;
    wdata_data_o = wdata_req_o ? beat_wd : '0;
  end

endmodule

// File: tb/tb_beta_exe_mem_unit.sv
// tb_beta_exe_mem_unit: directed bench for beta_exe_mem_unit.
// Runs with TimeoutCycles=4; split beats exercised when the macro is set.
module tb_beta_exe_mem_unit;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        lsu_en_i, lsu_op_i, lsu_unsigned_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_busy_o, lsu_done_o, lsu_err_o;
  logic [31:0] lsu_result_o;
  logic [1:0]  lsu_err_cause_o;
  logic        rdata_ready_i, rdata_valid_i, rdata_req_o;
  logic [31:0] rdata_data_i, rdata_addr_o;
  logic [3:0]  rdata_strb_o;
  logic        wdata_ready_i, wdata_valid_i, wdata_req_o;
  logic [31:0] wdata_data_o, wdata_addr_o;
  logic [3:0]  wdata_strb_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  beta_exe_mem_unit #(
    .DataWidth(32), .AddressWidth(32), .TimeoutCycles(4)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .lsu_en_i(lsu_en_i), .lsu_op_i(lsu_op_i),
    .lsu_size_i(lsu_size_i), .lsu_unsigned_i(lsu_unsigned_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_busy_o(lsu_busy_o), .lsu_done_o(lsu_done_o),
    .lsu_result_o(lsu_result_o), .lsu_err_o(lsu_err_o),
    .lsu_err_cause_o(lsu_err_cause_o),
    .rdata_ready_i(rdata_ready_i), .rdata_valid_i(rdata_valid_i),
    .rdata_data_i(rdata_data_i), .rdata_addr_o(rdata_addr_o),
    .rdata_strb_o(rdata_strb_o), .rdata_req_o(rdata_req_o),
    .wdata_ready_i(wdata_ready_i), .wdata_valid_i(wdata_valid_i),
    .wdata_data_o(wdata_data_o), .wdata_addr_o(wdata_addr_o),
    .wdata_strb_o(wdata_strb_o), .wdata_req_o(wdata_req_o)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic mem_idle();
    rdata_ready_i = 1'b0;
    rdata_valid_i = 1'b0;
    wdata_ready_i = 1'b0;
    wdata_valid_i = 1'b0;
  endtask

  task automatic issue(input logic op, input logic [1:0] sz,
                       input logic u, input logic [31:0] a,
                       input logic [31:0] wd, input logic keep);
    lsu_en_i       = 1'b1;
    lsu_op_i       = op;
    lsu_size_i     = sz;
    lsu_unsigned_i = u;
    lsu_addr_i     = a;
    lsu_wdata_i    = wd;
    @(negedge clk_i);
    if (!keep) lsu_en_i = 1'b0;
  endtask

  task automatic run(input string tag, input logic op,
                     input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic two_step,
                     input logic [31:0] e_addr, input logic [3:0] e_strb,
                     input logic [31:0] e_wd, input logic [31:0] e_res);
    issue(op, sz, u, a, wd, 1'b0);
    check({tag, "_busy"}, 32'(lsu_busy_o), 32'd1);
    if (op) begin
      check({tag, "_wreq"}, 32'(wdata_req_o), 32'd1);
      check({tag, "_rreq"}, 32'(rdata_req_o), 32'd0);
      check({tag, "_waddr"}, wdata_addr_o, e_addr);
      check({tag, "_wstrb"}, 32'(wdata_strb_o), 32'(e_strb));
      check({tag, "_wdata"}, wdata_data_o, e_wd);
      wdata_ready_i = 1'b1;
      wdata_valid_i = !two_step;
    end else begin
      check({tag, "_rreq"}, 32'(rdata_req_o), 32'd1);
      check({tag, "_wreq"}, 32'(wdata_req_o), 32'd0);
      check({tag, "_raddr"}, rdata_addr_o, e_addr);
      check({tag, "_rstrb"}, 32'(rdata_strb_o), 32'(e_strb));
      rdata_ready_i = 1'b1;
      rdata_valid_i = !two_step;
      rdata_data_i  = rd;
    end
    if (two_step) begin
      @(negedge clk_i);
      check({tag, "_wait_busy"}, 32'(lsu_busy_o), 32'd1);
      check({tag, "_wait_req"}, 32'(rdata_req_o | wdata_req_o), 32'd0);
      mem_idle();
      if (op) wdata_valid_i = 1'b1;
      else    rdata_valid_i = 1'b1;
    end
    @(negedge clk_i);
    mem_idle();
    check({tag, "_done"}, 32'(lsu_done_o), 32'd1);
    check({tag, "_err"}, 32'(lsu_err_o), 32'd0);
    check({tag, "_res"}, lsu_result_o, e_res);
    check({tag, "_nbusy"}, 32'(lsu_busy_o), 32'd0);
    @(negedge clk_i);
    check({tag, "_pulse"}, 32'(lsu_done_o), 32'd0);
  endtask

  task automatic err_run(input string tag, input logic op,
                         input logic [1:0] sz, input logic [31:0] a,
                         input logic [1:0] cause);
    issue(op, sz, 1'b0, a, 32'hFFFF_FFFF, 1'b1);
    check({tag, "_done"}, 32'(lsu_done_o), 32'd1);
    check({tag, "_err"}, 32'(lsu_err_o), 32'd1);
    check({tag, "_cause"}, 32'(lsu_err_cause_o), 32'(cause));
    check({tag, "_noreq"}, 32'(rdata_req_o | wdata_req_o), 32'd0);
    check({tag, "_res"}, lsu_result_o, 32'd0);
    @(negedge clk_i);
    check({tag, "_en_ign"}, 32'(lsu_done_o | lsu_busy_o), 32'd0);
    lsu_en_i = 1'b0;
  endtask

  int n;

  initial begin
    rstn_i = 1'b0;
    lsu_en_i = 1'b0; lsu_op_i = 1'b0; lsu_size_i = 2'b00;
    lsu_unsigned_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0;
    rdata_data_i = '0;
    mem_idle();
    repeat (3) @(negedge clk_i);
    check("rst_busy", 32'(lsu_busy_o), 32'd0);
    check("rst_done", 32'(lsu_done_o), 32'd0);
    check("rst_req", 32'(rdata_req_o | wdata_req_o), 32'd0);
    check("rst_res", lsu_result_o, 32'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    run("lw", 0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 1,
        32'h100, 4'b1111, 0, 32'hDEADBEEF);
    run("lb", 0, 2'b00, 0, 32'h103, 0, 32'h80AABBCC, 0,
        32'h100, 4'b1000, 0, 32'hFFFFFF80);
    run("lbu", 0, 2'b00, 1, 32'h103, 0, 32'h80AABBCC, 0,
        32'h100, 4'b1000, 0, 32'h00000080);
    run("lh", 0, 2'b01, 0, 32'h102, 0, 32'h80AABBCC, 1,
        32'h100, 4'b1100, 0, 32'hFFFF80AA);
    run("lhu", 0, 2'b01, 1, 32'h102, 0, 32'h80AABBCC, 0,
        32'h100, 4'b1100, 0, 32'h000080AA);
    run("lb_pos", 0, 2'b00, 0, 32'h101, 0, 32'h11227F33, 0,
        32'h100, 4'b0010, 0, 32'h0000007F);
    run("sh", 1, 2'b01, 0, 32'h102, 32'h1234, 0, 0,
        32'h100, 4'b1100, 32'h12340000, 0);
    run("sb", 1, 2'b00, 0, 32'h101, 32'hAB, 0, 1,
        32'h100, 4'b0010, 32'h0000AB00, 0);
    run("sw", 1, 2'b10, 0, 32'h204, 32'hCAFEF00D, 0, 0,
        32'h204, 4'b1111, 32'hCAFEF00D, 0);

    err_run("ld_ill", 0, 2'b11, 32'h100, 2'b11);
`ifdef BETA_LSU_MISALIGNED_SPLIT_EN
    issue(0, 2'b10, 0, 32'h101, 0, 1'b0);
    check("split_a1", rdata_addr_o, 32'h100);
    check("split_s1", 32'(rdata_strb_o), 32'h0000000E);
    rdata_ready_i = 1'b1; rdata_valid_i = 1'b1;
    rdata_data_i = 32'h44332211;
    @(negedge clk_i);
    check("split_a2", rdata_addr_o, 32'h104);
    check("split_s2", 32'(rdata_strb_o), 32'h00000001);
    rdata_data_i = 32'h88776655;
    @(negedge clk_i);
    mem_idle();
    check("split_done", 32'(lsu_done_o), 32'd1);
    check("split_res", lsu_result_o, 32'h55443322);
    @(negedge clk_i);
`else
    err_run("lw_mis", 0, 2'b10, 32'h101, 2'b01);
    err_run("sh_mis", 1, 2'b01, 32'h103, 2'b01);
`endif

    issue(0, 2'b10, 0, 32'h200, 0, 1'b0);
    rdata_ready_i = 1'b1;
    @(negedge clk_i);
    rdata_ready_i = 1'b0;
    n = 0;
    while (!lsu_done_o && n < 20) begin
      n++;
      @(negedge clk_i);
    end
    check("tmo_cycles", 32'(n), 32'd4);
    check("tmo_err", 32'(lsu_err_o), 32'd1);
    check("tmo_cause", 32'(lsu_err_cause_o), 32'd2);
    @(negedge clk_i);

    issue(0, 2'b10, 0, 32'h300, 0, 1'b0);
    rdata_ready_i = 1'b1;
    @(negedge clk_i);
    rdata_ready_i = 1'b0;
    check("mid_busy", 32'(lsu_busy_o), 32'd1);
    rstn_i = 1'b0;
    @(negedge clk_i);
    check("mrst_busy", 32'(lsu_busy_o), 32'd0);
    check("mrst_req", 32'(rdata_req_o | wdata_req_o), 32'd0);
    check("mrst_addr", rdata_addr_o, 32'd0);
    check("mrst_done", 32'(lsu_done_o | lsu_err_o), 32'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
